regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for three requesters into the register file, plus a busy scoreboard.
// MCU32X_WB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed priority.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  wb_valid,
  input  logic [14:0] wb_addr,
  input  logic [95:0] wb_data,
  output logic [2:0]  wb_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_busy1,
  output logic        chk_busy2
);

  function automatic logic [2:0] lsb3(input logic [2:0] v);
    logic [2:0] g;
    g = 3'b000;
    if (v[0])      g = 3'b001;
    else if (v[1]) g = 3'b010;
    else if (v[2]) g = 3'b100;
    return g;
  endfunction

  logic [2:0]  grant;
  logic        xfer;
  logic [1:0]  gidx;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic [31:0] busy_q, busy_d;

`ifdef MCU32X_WB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] rv, gr;

  // Rotate so the pointed-to requester sits at bit 0, pick lowest, rotate back.
  always_comb begin
    rv    = wb_valid;
    gr    = 3'b000;
    grant = 3'b000;
    unique case (ptr_q)
      2'd1: begin
        rv    = {wb_valid[0], wb_valid[2], wb_valid[1]};
        gr    = lsb3(rv);
        grant = {gr[1], gr[0], gr[2]};
      end
      2'd2: begin
        rv    = {wb_valid[1], wb_valid[0], wb_valid[2]};
        gr    = lsb3(rv);
        grant = {gr[0], gr[2], gr[1]};
      end
      default: begin
        gr    = lsb3(rv);
        grant = gr;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (gidx == 2'd2) ? 2'd0 : 2'(gidx + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb grant = lsb3(wb_valid);
`endif

  assign wb_ready = reset ? 3'b000 : grant;
  assign xfer     = |(wb_valid & wb_ready);

  always_comb begin
    gidx     = 2'd0;
    sel_addr = wb_addr[4:0];
    sel_data = wb_data[31:0];
    unique case (1'b1)
      wb_ready[1]: begin
        gidx     = 2'd1;
        sel_addr = wb_addr[9:5];
        sel_data = wb_data[63:32];
      end
      wb_ready[2]: begin
        gidx     = 2'd2;
        sel_addr = wb_addr[14:10];
        sel_data = wb_data[95:64];
      end
      default: begin
        gidx     = 2'd0;
        sel_addr = wb_addr[4:0];
        sel_data = wb_data[31:0];
      end
    endcase
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      rf_we_d    = (sel_addr != 5'd0);
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  // Clear before set so an issue in the same cycle as its writeback wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer) busy_d[sel_addr] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      busy_q     <= 32'd0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus contention/reset sequences.
// Contention expectations follow MCU32X_WB_ROUND_ROBIN_EN.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  wb_valid;
  logic [14:0] wb_addr;
  logic [95:0] wb_data;
  logic [2:0]  wb_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [2:0]  e_ready;
    logic        e_b1;
    logic        e_b2;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        cmp_rf;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [4:0] a2, input logic [4:0] a1,
    input logic [4:0] a0, input logic [31:0] d2, input logic [31:0] d1,
    input logic [31:0] d0, input logic iv, input logic [4:0] ird,
    input logic [4:0] c1, input logic [4:0] c2, input logic [2:0] er,
    input logic eb1, input logic eb2, input logic ewe,
    input logic [4:0] ewa, input logic [31:0] ewd, input logic cmp_rf);
    vec_t v;
    v.valid = valid; v.addr = {a2, a1, a0}; v.data = {d2, d1, d0};
    v.iv = iv; v.ird = ird; v.c1 = c1; v.c2 = c2;
    v.e_ready = er; v.e_b1 = eb1; v.e_b2 = eb2;
    v.e_we = ewe; v.e_waddr = ewa; v.e_wdata = ewd; v.cmp_rf = cmp_rf;
    return v;
  endfunction

  task automatic idle_inputs();
    wb_valid    = 3'b000;
    wb_addr     = '0;
    wb_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
  endtask

  logic [2:0] exp_g[3];
  logic [4:0] exp_a[3];

  initial begin
    // valid  a2 a1 a0  d2 d1 d0  iv ird  c1 c2  ready b1 b2  we waddr wdata cmp
    tbl[0]  = mk(3'b001, 0, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 5, 0,
                 3'b001, 0, 0, 1, 5, 32'hDEADBEEF, 1);
    tbl[1]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0,
                 3'b000, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    tbl[2]  = mk(3'b010, 0, 7, 0, 0, 32'h11112222, 0, 0, 0, 7, 0,
                 3'b010, 1, 0, 1, 7, 32'h11112222, 1);
    tbl[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0,
                 3'b000, 0, 0, 0, 7, 32'h11112222, 1);
    tbl[4]  = mk(3'b100, 9, 0, 0, 32'h99, 0, 0, 1, 9, 9, 0,
                 3'b100, 0, 0, 1, 9, 32'h99, 1);
    tbl[5]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 9, 7,
                 3'b000, 1, 0, 0, 9, 32'h99, 1);
    tbl[6]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9,
                 3'b000, 0, 1, 0, 9, 32'h99, 1);
    tbl[7]  = mk(3'b001, 0, 0, 0, 0, 0, 32'hCAFE, 0, 0, 0, 9,
                 3'b001, 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(3'b001, 0, 0, 3, 0, 0, 32'h12345678, 0, 0, 9, 3,
                 3'b001, 1, 0, 1, 3, 32'h12345678, 1);
    tbl[9]  = mk(3'b010, 0, 9, 0, 0, 32'hA5A5A5A5, 0, 0, 0, 9, 0,
                 3'b010, 1, 0, 1, 9, 32'hA5A5A5A5, 1);
    tbl[10] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0,
                 3'b000, 0, 0, 0, 9, 32'hA5A5A5A5, 1);

`ifdef MCU32X_WB_ROUND_ROBIN_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    exp_a[0] = 5'd1;   exp_a[1] = 5'd2;   exp_a[2] = 5'd3;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001;
    exp_a[0] = 5'd1;   exp_a[1] = 5'd1;   exp_a[2] = 5'd1;
`endif

    // Reset with a request pending
    idle_inputs();
    reset     = 1'b1;
    chk_addr1 = 5'd7;
    chk_addr2 = 5'd0;
    wb_valid  = 3'b001;
    wb_addr   = 15'd5;
    wb_data   = 96'h1;
    #1;
    chk("rst_ready", 32'(wb_ready), 32'h0);
    @(posedge clk); #1;
    chk("rst_we", 32'(rf_we), 32'h0);
    chk("rst_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_busy", 32'(chk_busy1), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      wb_valid    = tbl[i].valid;
      wb_addr     = tbl[i].addr;
      wb_data     = tbl[i].data;
      issue_valid = tbl[i].iv;
      issue_rd    = tbl[i].ird;
      chk_addr1   = tbl[i].c1;
      chk_addr2   = tbl[i].c2;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(wb_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d_busy1", i), 32'(chk_busy1), 32'(tbl[i].e_b1));
      chk($sformatf("v%0d_busy2", i), 32'(chk_busy2), 32'(tbl[i].e_b2));
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(tbl[i].e_we));
      if (tbl[i].cmp_rf) begin
        chk($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_waddr));
        chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].e_wdata);
      end
    end

    // Contention from a fresh reset
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    wb_valid = 3'b111;
    wb_addr  = {5'd3, 5'd2, 5'd1};
    wb_data  = {32'h300, 32'h200, 32'h100};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("cont%0d_ready", c), 32'(wb_ready), 32'(exp_g[c]));
      @(posedge clk); #1;
      chk($sformatf("cont%0d_waddr", c), 32'(rf_waddr), 32'(exp_a[c]));
      chk($sformatf("cont%0d_wdata", c), rf_wdata, 32'(exp_a[c]) << 8);
      chk($sformatf("cont%0d_we", c), 32'(rf_we), 32'h1);
    end

    // Mid-operation reset drops pending requests and the scoreboard
    idle_inputs();
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    @(posedge clk); #1;
    wb_valid    = 3'b111;
    issue_rd    = 5'd6;
    chk_addr1   = 5'd4;
    chk_addr2   = 5'd6;
    reset       = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(wb_ready), 32'h0);
    chk("mid_rst_busy_pre", 32'(chk_busy1), 32'h1);
    @(posedge clk); #1;
    chk("mid_rst_we", 32'(rf_we), 32'h0);
    chk("mid_rst_waddr", 32'(rf_waddr), 32'h0);
    chk("mid_rst_wdata", rf_wdata, 32'h0);
    chk("mid_rst_busy1", 32'(chk_busy1), 32'h0);
    chk("mid_rst_busy2", 32'(chk_busy2), 32'h0);
    reset = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    chk("post_rst_we", 32'(rf_we), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
